// File: rtl/alu_pkg.sv
// Shared ALU package: CRC engine FSM states, CRC function encodings (shared
// with the combinational CRC unit) and a constant clog2 helper.
package alu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_NEXT  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } crc_state_e;

  localparam logic CRC_FN_CHECK = 1'b0;
  localparam logic CRC_FN_JOIN  = 1'b1;

  // Ceiling log2 for sizing counters at elaboration time; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_crc_step.sv
// Combinational CRC fold: shifts STEP_W bits (MSB first) into the remainder
// using long-division form. Also exposes the remainder after the first stage
// so a single-bit fold (the zero augmentation) can reuse the same chain.
// Ports:
//   rem_in    current remainder (KEY_W-1 bits)
//   bits      bits to fold, bits[STEP_W-1] first
//   key       generator without its implicit leading 1
//   rem_out   remainder after all STEP_W stages
//   rem_first remainder after the first stage only
module alu_crc_step #(
  parameter int KEY_W  = 9,
  parameter int STEP_W = 8
) (
  input  logic [KEY_W-2:0]  rem_in,
  input  logic [STEP_W-1:0] bits,
  input  logic [KEY_W-2:0]  key,
  output logic [KEY_W-2:0]  rem_out,
  output logic [KEY_W-2:0]  rem_first
);

  localparam int REM_W = KEY_W - 1;

  logic [REM_W-1:0] r;
  logic             fb;

  always_comb begin
    r         = rem_in;
    fb        = 1'b0;
    rem_first = '0;
    for (int i = 0; i < STEP_W; i++) begin
      fb = r[REM_W-1];
      r  = (r << 1) | REM_W'(bits[STEP_W-1-i]);
      if (fb) r = r ^ key;
      if (i == 0) rem_first = r;
    end
    rem_out = r;
  end

endmodule

// File: rtl/alu_crc_stream.sv
// Multi-beat sequential CRC engine. Frames of DATA_W-bit beats arrive on the
// s_* stream and are folded STEP_W bits per cycle into a remainder. In join
// mode KEY_W-1 zero bits are appended and the remainder is the CRC to append;
// in check mode the remainder of the received codeword flags an error.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready     input beat handshake
//   s_data, s_last      beat (MSB first on the wire), end-of-frame marker
//   s_funct, s_key      mode and generator, taken from the first beat only
//   m_valid/m_ready     result handshake
//   m_crc, m_err        final remainder, check-mode error flag
//   m_beats             beats in the frame, saturating
//   dbg_state_o         current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. Ready never depends on valid. Once m_valid rises, m_crc, m_err
// and m_beats hold until the edge where m_ready is sampled high.
module alu_crc_stream
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int KEY_W  = 9,
  parameter int STEP_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  input  logic               s_funct,
  input  logic [KEY_W-1:0]   s_key,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [KEY_W-2:0]   m_crc,
  output logic               m_err,
  output logic [CNT_W-1:0]   m_beats,
  output crc_state_e         dbg_state_o
);

  localparam int REM_W  = KEY_W - 1;
  localparam int NSTEPS = DATA_W / STEP_W;
  localparam int SCNT_W = clog2(NSTEPS) + 1;
  localparam int FCNT_W = clog2(KEY_W) + 1;

  crc_state_e        state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [REM_W-1:0]  key_q, key_d;
  logic              funct_q, funct_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  beats_q, beats_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [STEP_W-1:0] step_bits;
  logic [REM_W-1:0]  rem_step, rem_first;

  // The generator MSB is implied to be 1 and never looked at.
  logic unused_key_msb;
  assign unused_key_msb = s_key[KEY_W-1];

  // During FLUSH the chain sees zeros and only its first stage is used.
  assign step_bits = (state_q == ST_FLUSH) ? '0 : sh_q[DATA_W-1 -: STEP_W];

  alu_crc_step #(.KEY_W(KEY_W), .STEP_W(STEP_W)) u_step (
    .rem_in    (rem_q),
    .bits      (step_bits),
    .key       (key_q),
    .rem_out   (rem_step),
    .rem_first (rem_first)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    key_d   = key_q;
    funct_d = funct_q;
    last_d  = last_q;
    beats_d = beats_q;
    scnt_d  = scnt_q;
    fcnt_d  = fcnt_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sh_d    = s_data;
          funct_d = s_funct;
          key_d   = s_key[REM_W-1:0];
          last_d  = s_last;
          rem_d   = '0;
          beats_d = CNT_W'(1);
          scnt_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        rem_d  = rem_step;
        sh_d   = sh_q << STEP_W;
        scnt_d = scnt_q + SCNT_W'(1);
        if (scnt_q == SCNT_W'(NSTEPS - 1)) begin
          if (!last_q) begin
            state_d = ST_NEXT;
          end else if (funct_q == CRC_FN_JOIN) begin
            fcnt_d  = '0;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_NEXT: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sh_d   = s_data;
          last_d = s_last;
          if (beats_q != {CNT_W{1'b1}}) beats_d = beats_q + CNT_W'(1);
          scnt_d  = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_FLUSH: begin
        rem_d  = rem_first;
        fcnt_d = fcnt_q + FCNT_W'(1);
        if (fcnt_q == FCNT_W'(REM_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        m_valid = 1'b1;
        if (m_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
      key_q   <= '0;
      funct_q <= 1'b0;
      last_q  <= 1'b0;
      beats_q <= '0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      key_q   <= key_d;
      funct_q <= funct_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Results are only presented in DONE; elsewhere they read as zero.
  assign m_crc       = m_valid ? rem_q : '0;
  assign m_err       = m_valid && (funct_q == CRC_FN_CHECK) && (|rem_q);
  assign m_beats     = m_valid ? beats_q : '0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_crc_stream.sv
module tb_alu_crc_stream;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int KEY_W  = 9;
  localparam int STEP_W = 8;
  localparam int CNT_W  = 16;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic [DATA_W-1:0]  s_data;
  logic               s_last;
  logic               s_funct;
  logic [KEY_W-1:0]   s_key;
  logic               m_valid;
  logic               m_ready;
  logic [KEY_W-2:0]   m_crc;
  logic               m_err;
  logic [CNT_W-1:0]   m_beats;
  crc_state_e         dbg_state;

  alu_crc_stream #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .STEP_W(STEP_W), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_funct     (s_funct),
    .s_key       (s_key),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_crc       (m_crc),
    .m_err       (m_err),
    .m_beats     (m_beats),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [24:0] exp_q[$];  // {err, beats[15:0], crc[7:0]}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Long division of the whole frame value by the full generator.
  function automatic logic [7:0] model_crc(input logic [31:0] bt [3], input int nb,
                                           input logic join_mode, input logic [8:0] key);
    logic [127:0] m;
    logic [8:0]   k;
    k = {1'b1, key[7:0]};
    m = '0;
    for (int i = 0; i < nb; i++) m = (m << 32) | 128'(bt[i]);
    if (join_mode) m = m << 8;
    for (int i = 127; i >= 8; i--) if (m[i]) m[i -: 9] = m[i -: 9] ^ k;
    return m[7:0];
  endfunction

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [31:0] d, input logic last, input logic fn,
                           input logic [8:0] key);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    s_funct = fn;
    s_key   = key;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_ready observed=0 expected=1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!m_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Waits for the result, compares against the scoreboard head, consumes it.
  task automatic check_result(input string tag, input int exp_lat);
    int n;
    logic [24:0] e;
    wait_valid(n);
    check({tag, "_valid"}, 32'(m_valid), 32'd1);
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    e = exp_q.pop_front();
    check({tag, "_crc"}, 32'(m_crc), 32'(e[7:0]));
    check({tag, "_beats"}, 32'(m_beats), 32'(e[23:8]));
    check({tag, "_err"}, 32'(m_err), 32'(e[24]));
    check({tag, "_sready_done"}, 32'(s_ready), 32'd0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    check({tag, "_idle_sready"}, 32'(s_ready), 32'd1);
    check({tag, "_idle_mvalid"}, 32'(m_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] bt [3];
    logic [7:0]  c;
    logic        seen;
    int          nb;
    logic        fn;
    logic [8:0]  key;
    int          n;

    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    s_funct = 1'b0; s_key = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_sready", 32'(s_ready), 32'd1);
    check("rst_mvalid", 32'(m_valid), 32'd0);
    check("rst_mcrc", 32'(m_crc), 32'd0);
    check("rst_merr", 32'(m_err), 32'd0);
    check("rst_mbeats", 32'(m_beats), 32'd0);

    // Join, single beat: x^8 mod 0x107 = 0x07
    exp_q.push_back({1'b0, 16'd1, 8'h07});
    send_beat(32'h0000_0001, 1'b1, CRC_FN_JOIN, 9'h107);
    check("join1_sready_shift", 32'(s_ready), 32'd0);
    check_result("join1", 12);

    // Check, valid codeword
    exp_q.push_back({1'b0, 16'd1, 8'h00});
    send_beat(32'h0000_0107, 1'b1, CRC_FN_CHECK, 9'h107);
    check_result("chk_ok", 4);

    // Check, corrupted codeword, with 10 cycles of backpressure in DONE
    exp_q.push_back({1'b1, 16'd1, 8'h0F});
    send_beat(32'h0000_0108, 1'b1, CRC_FN_CHECK, 9'h107);
    wait_valid(n);
    check("chk_bad_latency", 32'(n), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_mvalid", 32'(m_valid), 32'd1);
      check("bp_mcrc", 32'(m_crc), 32'h0F);
      check("bp_merr", 32'(m_err), 32'd1);
      check("bp_sready", 32'(s_ready), 32'd0);
    end
    check_result("chk_bad", -1);

    // Join, two beats with 3 idle cycles in NEXT
    exp_q.push_back({1'b0, 16'd2, 8'h07});
    send_beat(32'h0000_0000, 1'b0, CRC_FN_JOIN, 9'h107);
    check("two_sready_shift", 32'(s_ready), 32'd0);
    check("two_state_shift", 32'(dbg_state), 32'(ST_SHIFT));
    repeat (4) @(posedge clk);
    #1;
    check("two_sready_next", 32'(s_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("two_state_wait", 32'(dbg_state), 32'(ST_NEXT));
    check("two_sready_wait", 32'(s_ready), 32'd1);
    send_beat(32'h0000_0001, 1'b1, CRC_FN_JOIN, 9'h107);
    check_result("two", 12);

    // Reset during the 2nd SHIFT cycle discards the frame
    send_beat(32'h0000_0001, 1'b1, CRC_FN_JOIN, 9'h107);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_sready", 32'(s_ready), 32'd1);
    check("mid_rst_mvalid", 32'(m_valid), 32'd0);
    check("mid_rst_mcrc", 32'(m_crc), 32'd0);
    check("mid_rst_merr", 32'(m_err), 32'd0);
    check("mid_rst_mbeats", 32'(m_beats), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (m_valid) seen = 1'b1;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    exp_q.push_back({1'b0, 16'd1, 8'h07});
    send_beat(32'h0000_0001, 1'b1, CRC_FN_JOIN, 9'h107);
    check_result("after_rst", 12);

    // Key MSB is ignored: 0x007 behaves as 0x107
    exp_q.push_back({1'b0, 16'd1, 8'h07});
    send_beat(32'h0000_0001, 1'b1, CRC_FN_JOIN, 9'h007);
    check_result("key_msb", 12);

    // Mode/key taken from first beat only
    bt[0] = 32'h1234_5678; bt[1] = 32'h9ABC_DEF0; bt[2] = '0;
    c = model_crc(bt, 2, 1'b1, 9'h107);
    exp_q.push_back({1'b0, 16'd2, c});
    send_beat(bt[0], 1'b0, CRC_FN_JOIN, 9'h107);
    send_beat(bt[1], 1'b1, CRC_FN_CHECK, 9'h1FF);
    check_result("latch", 12);

    // Random frames against the long-division model
    for (int f = 0; f < 6; f++) begin
      nb  = $urandom_range(1, 3);
      fn  = 1'($urandom_range(0, 1));
      key = 9'($urandom_range(0, 511));
      for (int i = 0; i < 3; i++) bt[i] = $urandom;
      c = model_crc(bt, nb, fn, key);
      exp_q.push_back({(fn == CRC_FN_CHECK) && (c != 8'h00), 16'(nb), c});
      for (int i = 0; i < nb; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        send_beat(bt[i], (i == nb - 1), fn, key);
      end
      check_result("rand", (fn == CRC_FN_JOIN) ? 12 : 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_crc_stream.md
Name: alu_crc_stream

Overview:
Multi-cycle, multi-beat CRC engine and the sequential successor of the single-word combinational CRC unit in the ALU. It accepts a frame of DATA_W-bit beats over a valid/ready stream and folds STEP_W bits per cycle into a remainder register. It either appends a CRC (join) or checks a received codeword (error detection). The result is returned on a second valid/ready channel, so the ALU issue logic can stall on it.

Parameters:
DATA_W, 32, beat width; must be a multiple of STEP_W.
KEY_W, 9, generator width including the leading 1; remainder width is KEY_W-1; minimum 2.
STEP_W, 8, bits folded per SHIFT cycle; range 1..DATA_W.
CNT_W, 16, width of the beat counter.

Ports:
clk  in  1  clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
s_valid  in  1  input beat valid.
s_ready  out  1  input beat accepted when s_valid && s_ready.
s_data  in  DATA_W  beat; MSB is the first bit on the wire.
s_last  in  1  final beat of the frame.
s_funct  in  1  0 = error detection, 1 = join; sampled on the first beat only.
s_key  in  KEY_W  generator polynomial; sampled on the first beat only.
m_valid  out  1  result valid.
m_ready  in  1  result consumed when m_valid && m_ready.
m_crc  out  KEY_W-1  final remainder (join: the CRC to append).
m_err  out  1  check mode: remainder != 0; join mode: 0.
m_beats  out  CNT_W  beats in the frame, saturating at all-ones.

Behaviour:
- Reset: rst=1 at an edge forces state IDLE, remainder 0, counters 0, s_ready=1, m_valid=0, m_crc=0, m_err=0, m_beats=0. This applies mid-frame too; the partial frame is discarded and no result is produced.
- Remainder update per bit b (division form, matches combinational long division): fb = rem[KEY_W-2]; rem <= {rem[KEY_W-3:0], b} ^ (fb ? key_q[KEY_W-2:0] : 0). key_q[KEY_W-1] is ignored and treated as 1.
- STEP_W bits are folded per cycle, MSB first, through an unrolled chain of STEP_W bit stages.
- States and transitions:
  - IDLE: s_ready=1. On accept, latch beat into shift reg, latch funct_q and key_q, set rem=0 and beats=1, then go to SHIFT.
  - SHIFT: s_ready=0. Stays DATA_W/STEP_W cycles. After the last step: s_last_q=0 -> NEXT; s_last_q=1 && funct_q=1 -> FLUSH; s_last_q=1 && funct_q=0 -> DONE.
  - NEXT: s_ready=1. On accept, latch the beat and increment beats (saturating), then go to SHIFT. s_funct and s_key are ignored here.
  - FLUSH: folds one zero bit per cycle for KEY_W-1 cycles (the augmentation), then goes to DONE.
  - DONE: m_valid=1; m_crc, m_err and m_beats are stable. On m_ready go to IDLE. s_ready=0 in DONE, so there is no overlap with the next frame.
- Latency from the accept edge of the last beat: DATA_W/STEP_W cycles for check; DATA_W/STEP_W + KEY_W-1 cycles for join.
- Throughput: one beat per DATA_W/STEP_W + 1 cycles.
- m_valid held high with m_ready=0: all outputs hold indefinitely.
- s_valid low in NEXT: the engine waits and rem holds.
- Single-beat frame: accepted in IDLE with s_last=1.
- STEP_W=DATA_W: SHIFT lasts one cycle.
- Counters: SHIFT counter width is clog2(DATA_W/STEP_W)+1; FLUSH counter width is clog2(KEY_W)+1. No wrap is possible.

Decomposition:
- Shared package alu_pkg holds:
  - the FSM state enum (IDLE, SHIFT, NEXT, FLUSH, DONE);
  - funct encodings CRC_FN_CHECK=0 and CRC_FN_JOIN=1, shared with the combinational CRC unit;
  - the clog2 helper.
- One sub-module, alu_crc_step: combinational, folds STEP_W bits into the remainder (ports rem_in, bits, key, rem_out). It is instantiated once for SHIFT; FLUSH reuses bit 0 of the same chain via a zero-bit mux.

Test Plan (DATA_W=32, KEY_W=9, STEP_W=8, key=9'h107):
- Join, single beat 32'h00000001, s_last=1 -> m_valid 12 cycles after accept; m_crc=8'h07, m_err=0, m_beats=1.
- Check, single beat 32'h00000107 -> m_valid 4 cycles after accept, m_crc=8'h00, m_err=0. Then check 32'h00000108 -> m_crc=8'h0F, m_err=1.
- Join, two beats 32'h00000000 then 32'h00000001 with 3 idle cycles of s_valid=0 between them -> m_crc=8'h07, m_beats=2, s_ready high only in IDLE/NEXT.
- Backpressure: hold m_ready=0 for 10 cycles in DONE -> m_valid and outputs stable, s_ready=0. Pulse m_ready -> IDLE next cycle and s_ready=1.
- Reset mid-frame: assert rst during the 2nd SHIFT cycle -> next cycle all outputs at reset values. A fresh frame 32'h00000001 join then gives m_crc=8'h07.
- Mode/key latch: change s_funct and s_key on the 2nd beat -> result follows first-beat values. Random frames are compared against a bitwise reference model.
